// File: rtl/fb_fetch_unit.sv
// Firebird instruction-fetch stage.
// Owns the program counter, issues single-outstanding word fetches to
// instruction memory, offers each fetched pc/instruction to the hazard unit
// and drives the IF/ID pipeline register.
//
// Optional build macro: FB_FETCH_ALIGN_CHECK_EN
//   defined   : a misaligned redirect target pulses fetch_misalign, suppresses
//               one fetch (bubble) and fetch continues at target & ~3
//   undefined : target[1:0] silently forced to 0, fetch_misalign tied low
//
// state  | meaning
// S_REQ  | request pending on the memory port
// S_WAIT | request accepted, awaiting the response
// S_HOLD | response captured, decode stalled by lock

module fb_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] predict_pc,
  input  logic        pc_src,
  input  logic [31:0] predict_err_pc,
  input  logic        address_src,
  input  logic        register_rst,
  input  logic        lock,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic        fetch_misalign
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] hold_inst;
  logic        stale;
  logic        misalign_q;

  logic        offer;
  logic        redirect;
  logic        advance;
  logic        b2b;
  logic        accepted;
  logic        old_out;
  logic        tgt_misalign;
  logic [31:0] seq_pc;
  logic [31:0] next_pc;
  logic [31:0] new_pc;

  // An instruction is offered when a live response returns or one is held.
  assign offer    = !rst && ((state == S_WAIT && imem_rvalid) || state == S_HOLD);
  assign redirect = address_src | register_rst;
  assign advance  = offer && !lock && !redirect;
  assign seq_pc   = fetch_pc + 32'd4;

  // Next-pc selection: mispredict correction > predicted taken > sequential.
  always_comb begin
    next_pc = fetch_pc;
    if (address_src)
      next_pc = predict_err_pc;
    else if (advance)
      next_pc = pc_src ? predict_pc : seq_pc;
  end

  assign new_pc = {next_pc[31:2], 2'b00};

`ifdef FB_FETCH_ALIGN_CHECK_EN
  assign tgt_misalign = !rst &&
                        ((address_src && (predict_err_pc[1:0] != 2'b00)) ||
                         (advance && pc_src && (predict_pc[1:0] != 2'b00)));
`else
  assign tgt_misalign = 1'b0;
  assign misalign_q   = 1'b0;
`endif

  // Back-to-back issue of the next pc in the same cycle the response is consumed.
  assign b2b      = (state == S_WAIT) && advance && !tgt_misalign;
  // A stale request still in flight blocks new issue to keep one outstanding.
  assign imem_req = !rst && (((state == S_REQ) && !stale && !misalign_q) || b2b);
  assign imem_addr = rst ? RESET_PC : (b2b ? new_pc : fetch_pc);
  assign accepted = imem_req && imem_ready;
  // A previously issued request whose response has not yet come back.
  assign old_out  = !imem_rvalid && ((state == S_WAIT) || stale);

  assign if_valid = offer;
  assign if_pc    = rst ? RESET_PC : fetch_pc;
  assign if_inst  = !offer ? NOP_INST : ((state == S_HOLD) ? hold_inst : imem_rdata);

  // Fetch FSM, program counter, hold register and stale-response tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_REQ;
      fetch_pc  <= RESET_PC;
      hold_inst <= NOP_INST;
      stale     <= old_out;
    end else begin
      fetch_pc <= new_pc;
      if (redirect) begin
        state     <= S_REQ;
        stale     <= old_out || accepted;
        hold_inst <= NOP_INST;
      end else begin
        stale <= stale && !imem_rvalid;
        case (state)
          S_REQ: begin
            if (accepted)
              state <= S_WAIT;
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              if (lock) begin
                hold_inst <= imem_rdata;
                state     <= S_HOLD;
              end else if (accepted) begin
                state <= S_WAIT;
              end else begin
                state <= S_REQ;
              end
            end
          end
          S_HOLD: begin
            if (!lock) begin
              hold_inst <= NOP_INST;
              state     <= S_REQ;
            end
          end
          default: state <= S_REQ;
        endcase
      end
    end
  end

  // IF/ID register: flush beats stall; an unfilled slot becomes a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_pc    <= 32'd0;
      id_inst  <= NOP_INST;
    end else if (register_rst) begin
      id_valid <= 1'b0;
      id_inst  <= NOP_INST;
    end else if (lock) begin
      id_valid <= id_valid;
    end else if (advance) begin
      id_valid <= 1'b1;
      id_pc    <= fetch_pc;
      id_inst  <= if_inst;
    end else begin
      id_valid <= 1'b0;
      id_inst  <= NOP_INST;
    end
  end

`ifdef FB_FETCH_ALIGN_CHECK_EN
  // One-cycle flag for a misaligned redirect target.
  always_ff @(posedge clk) begin
    if (rst)
      misalign_q <= 1'b0;
    else
      misalign_q <= tgt_misalign;
  end
`endif

  assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_fb_fetch_unit.sv
// Bench for fb_fetch_unit: directed sequences followed by randomized memory
// timing and hazard-unit decisions, checked against a program-order model.
module tb_fb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] predict_pc;
  logic        pc_src;
  logic [31:0] predict_err_pc;
  logic        address_src;
  logic        register_rst;
  logic        lock;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        fetch_misalign;

  fb_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst(rst),
    .predict_pc(predict_pc), .pc_src(pc_src),
    .predict_err_pc(predict_err_pc), .address_src(address_src),
    .register_rst(register_rst), .lock(lock),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid),
    .fetch_misalign(fetch_misalign)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_commit = 0;

  logic        mem_rand;
  logic        pend_valid;
  logic [31:0] pend_addr;
  int          pend_cnt;

  logic [31:0] exp_pc;
  logic        exp_idv;
  logic [31:0] exp_idpc;
  logic [31:0] exp_idinst;
  logic        exp_mis;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: drive response/ready just after each rising edge.
  initial begin
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    pend_valid  = 1'b0;
    pend_addr   = 32'd0;
    pend_cnt    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (pend_valid && pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_fn(pend_addr);
        pend_valid  = 1'b0;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pend_valid) pend_cnt--;
      end
      imem_ready = mem_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Memory: record accepted requests mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (imem_req && imem_ready) begin
        check_val("single_out", {31'd0, pend_valid}, 32'd0);
        pend_valid = 1'b1;
        pend_addr  = imem_addr;
        pend_cnt   = mem_rand ? int'($urandom_range(0, 2)) : 0;
      end
    end
  end

  // Program-order scoreboard.
  initial begin
    logic commit;
    logic mis;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_pc     = RESET_PC;
        exp_idv    = 1'b0;
        exp_idpc   = 32'd0;
        exp_idinst = NOP_INST;
        exp_mis    = 1'b0;
      end else begin
        check_val("id_valid", {31'd0, id_valid}, {31'd0, exp_idv});
        check_val("id_pc", id_pc, exp_idpc);
        check_val("id_inst", id_inst, exp_idinst);
        check_val("misalign", {31'd0, fetch_misalign}, {31'd0, exp_mis});
        if (if_valid) begin
          check_val("if_pc", if_pc, exp_pc);
          check_val("if_inst", if_inst, mem_fn(exp_pc));
        end
        if (imem_req) check_val("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        commit = if_valid && !lock && !address_src && !register_rst;
        mis = 1'b0;
`ifdef FB_FETCH_ALIGN_CHECK_EN
        mis = (address_src && predict_err_pc[1:0] != 2'b00) ||
              (commit && pc_src && predict_pc[1:0] != 2'b00);
`endif
        if (register_rst) begin
          exp_idv    = 1'b0;
          exp_idinst = NOP_INST;
        end else if (lock) begin
          exp_idv = exp_idv;
        end else if (commit) begin
          exp_idv    = 1'b1;
          exp_idpc   = exp_pc;
          exp_idinst = mem_fn(exp_pc);
          n_commit++;
        end else begin
          exp_idv    = 1'b0;
          exp_idinst = NOP_INST;
        end
        if (address_src)
          exp_pc = predict_err_pc & ~32'd3;
        else if (commit)
          exp_pc = pc_src ? (predict_pc & ~32'd3) : exp_pc + 32'd4;
        exp_mis = mis;
      end
    end
  end

  task automatic clear_hz();
    pc_src = 1'b0;
    address_src = 1'b0;
    register_rst = 1'b0;
    lock = 1'b0;
  endtask

  initial begin
    logic [31:0] tmp;
    mem_rand = 1'b0;
    rst = 1'b1;
    predict_pc = 32'd0;
    predict_err_pc = 32'd0;
    clear_hz();

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_req", {31'd0, imem_req}, 32'd0);
    check_val("rst_addr", imem_addr, RESET_PC);
    check_val("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check_val("rst_if_pc", if_pc, RESET_PC);
    check_val("rst_if_inst", if_inst, NOP_INST);
    check_val("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check_val("rst_id_pc", id_pc, 32'd0);
    check_val("rst_id_inst", id_inst, NOP_INST);
    check_val("rst_misalign", {31'd0, fetch_misalign}, 32'd0);

    // Zero-wait streaming: 0,4,8,C.
    tick(); rst = 1'b0;
    @(negedge clk);
    check_val("c0_req", {31'd0, imem_req}, 32'd1);
    check_val("c0_addr", imem_addr, 32'h0);
    tick(); @(negedge clk);
    check_val("c1_addr", imem_addr, 32'h4);
    check_val("c1_if_valid", {31'd0, if_valid}, 32'd1);
    tick(); @(negedge clk);
    check_val("c2_addr", imem_addr, 32'h8);
    check_val("c2_id_pc", id_pc, 32'h0);
    check_val("c2_id_valid", {31'd0, id_valid}, 32'd1);
    tick(); @(negedge clk);
    check_val("c3_addr", imem_addr, 32'hC);
    check_val("c3_id_pc", id_pc, 32'h4);

    // Predicted taken with no bubble.
    tick(); pc_src = 1'b1; predict_pc = 32'h100;
    @(negedge clk);
    check_val("pt_addr", imem_addr, 32'h100);
    tick(); pc_src = 1'b0;
    @(negedge clk);
    check_val("pt_if_valid", {31'd0, if_valid}, 32'd1);
    check_val("pt_if_pc", if_pc, 32'h100);
    check_val("pt_next", imem_addr, 32'h104);

    // Lock for three cycles.
    tick(); lock = 1'b1;
    @(negedge clk);
    check_val("lk0_req", {31'd0, imem_req}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick(); @(negedge clk);
      check_val("lk_req", {31'd0, imem_req}, 32'd0);
      check_val("lk_if_pc", if_pc, 32'h104);
      check_val("lk_id_pc", id_pc, 32'h100);
    end
    tick(); lock = 1'b0;
    @(negedge clk);
    tick(); @(negedge clk);
    check_val("rel_addr", imem_addr, 32'h108);
    check_val("rel_req", {31'd0, imem_req}, 32'd1);
    check_val("rel_id_pc", id_pc, 32'h104);

    // Mispredict to the top of memory, wrap to zero.
    tick(); address_src = 1'b1; register_rst = 1'b1; predict_err_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    tick(); clear_hz();
    @(negedge clk);
    check_val("wr_addr", imem_addr, 32'hFFFF_FFFC);
    check_val("wr_flush", {31'd0, id_valid}, 32'd0);
    tick(); @(negedge clk);
    check_val("wr_if_pc", if_pc, 32'hFFFF_FFFC);
    check_val("wr_wrap", imem_addr, 32'h0);

    // Misaligned redirect target.
    tick(); address_src = 1'b1; register_rst = 1'b1; predict_err_pc = 32'h42;
    @(negedge clk);
    tick(); clear_hz();
    @(negedge clk);
`ifdef FB_FETCH_ALIGN_CHECK_EN
    check_val("ma_flag", {31'd0, fetch_misalign}, 32'd1);
    check_val("ma_suppress", {31'd0, imem_req}, 32'd0);
    tick(); @(negedge clk);
    check_val("ma_flag_clr", {31'd0, fetch_misalign}, 32'd0);
`else
    check_val("ma_flag", {31'd0, fetch_misalign}, 32'd0);
`endif
    check_val("ma_req", {31'd0, imem_req}, 32'd1);
    check_val("ma_addr", imem_addr, 32'h40);

    // Randomized memory timing and hazard decisions, with one mid-run reset.
    mem_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst = (i == 1500 || i == 1501);
      lock = ($urandom_range(0, 3) == 0);
      pc_src = ($urandom_range(0, 4) == 0);
      tmp = $urandom;
      if ($urandom_range(0, 3) != 0) tmp[1:0] = 2'b00;
      predict_pc = tmp;
      address_src = ($urandom_range(0, 11) == 0);
      tmp = $urandom;
      if ($urandom_range(0, 3) != 0) tmp[1:0] = 2'b00;
      predict_err_pc = tmp;
      register_rst = address_src ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
    end
    tick();
    rst = 1'b0;
    clear_hz();
    @(negedge clk);
    check_val("progress", {31'd0, (n_commit > 100)}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
